// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (counters, syncs, data enable, line/frame strobes)
//
// Ports:
//   i_clk_74M      pixel clock
//   i_rst          synchronous reset, active-high
//   i_en           count enable; low freezes the raster position
//   o_hcnt/o_vcnt  pixel/line counters, active video starts at (0,0)
//   o_hs/o_vs      syncs with HS_POL/VS_POL active level
//   o_de           high inside the active area
//   o_line_start   one-cycle pulse when o_hcnt becomes 0
//   o_frame_start  one-cycle pulse when (o_hcnt,o_vcnt) becomes (0,0)
//   o_frame_cnt    frames started since reset, wrapping
module video_timing_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        i_clk_74M,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [11:0] o_hcnt,
  output logic [11:0] o_vcnt,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic [15:0] o_frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_totals
    $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
  end

  logic [11:0] r_hcnt, r_vcnt, w_hn, w_vn;
  logic [15:0] r_frame_cnt;
  logic        r_hs, r_vs, r_de, r_line_start, r_frame_start;
  logic        w_h_last, w_de, w_hs_act, w_vs_act, w_line, w_frame;

  // Every decode looks at the next position so the registered flags line up
  // with the registered counters in the same cycle.
  always_comb begin
    w_h_last = r_hcnt == H_LAST;
    w_hn     = !i_en ? r_hcnt : w_h_last ? 12'd0 : r_hcnt + 12'd1;
    w_vn     = !(i_en && w_h_last) ? r_vcnt : (r_vcnt == V_LAST) ? 12'd0 : r_vcnt + 12'd1;
    w_de     = int'(w_hn) < H_ACTIVE && int'(w_vn) < V_ACTIVE;
    w_hs_act = int'(w_hn) >= H_ACTIVE + H_FP && int'(w_hn) < H_ACTIVE + H_FP + H_SYNC;
    w_vs_act = int'(w_vn) >= V_ACTIVE + V_FP && int'(w_vn) < V_ACTIVE + V_FP + V_SYNC;
    w_line   = i_en && w_hn == 12'd0;
    w_frame  = w_line && w_vn == 12'd0;
  end

  always_ff @(posedge i_clk_74M) begin
    if (i_rst) begin
      r_hcnt        <= H_LAST;
      r_vcnt        <= V_LAST;
      r_de          <= 1'b0;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 16'd0;
    end else begin
      r_hcnt        <= w_hn;
      r_vcnt        <= w_vn;
      r_de          <= w_de;
      r_hs          <= w_hs_act ? HS_POL : ~HS_POL;
      r_vs          <= w_vs_act ? VS_POL : ~VS_POL;
      r_line_start  <= w_line;
      r_frame_start <= w_frame;
      r_frame_cnt   <= w_frame ? r_frame_cnt + 16'd1 : r_frame_cnt;
    end
  end

  assign o_hcnt        = r_hcnt;
  assign o_vcnt        = r_vcnt;
  assign o_hs          = r_hs;
  assign o_vs          = r_vs;
  assign o_de          = r_de;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized self-checking bench against a linear-pixel-index model
module tb_video_timing_gen;
  localparam int HA = 16, HF = 4, HSW = 3, HB = 5, HT = HA + HF + HSW + HB;
  localparam int VA = 10, VF = 2, VSW = 2, VB = 3, VT = VA + VF + VSW + VB;
  localparam int PT = HT * VT;
  localparam logic HSP = 1'b1, VSP = 1'b0;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [11:0] hcnt, vcnt;
  logic        hs, vs, de, ls, fs;
  logic [15:0] fcnt;
  logic [44:0] obs;

  int checks = 0, errors = 0;
  int p = 0, m_fc = 0;
  bit m_ls = 0, m_fs = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .i_clk_74M(clk), .i_rst(rst), .i_en(en),
    .o_hcnt(hcnt), .o_vcnt(vcnt), .o_hs(hs), .o_vs(vs), .o_de(de),
    .o_line_start(ls), .o_frame_start(fs), .o_frame_cnt(fcnt)
  );

  always #5 clk = ~clk;
  assign obs = {hcnt, vcnt, hs, vs, de, ls, fs, fcnt};

  // The model tracks one linear index over the frame; position and flags follow arithmetically.
  function automatic logic [44:0] expv();
    int h, v;
    logic e_hs, e_vs, e_de;
    h = p % HT;
    v = p / HT;
    e_de = h < HA && v < VA;
    e_hs = (h >= HA + HF && h < HA + HF + HSW) ? HSP : ~HSP;
    e_vs = (v >= VA + VF && v < VA + VF + VSW) ? VSP : ~VSP;
    return {12'(h), 12'(v), e_hs, e_vs, e_de, m_ls, m_fs, 16'(m_fc)};
  endfunction

  task automatic tick(input logic r, input logic e);
    rst = r;
    en = e;
    @(posedge clk);
    #1;
    if (r) begin
      p = PT - 1; m_fc = 0; m_ls = 0; m_fs = 0;
    end else if (e) begin
      p = (p + 1) % PT;
      m_ls = (p % HT) == 0;
      m_fs = p == 0;
      if (m_fs) m_fc = (m_fc + 1) % 65536;
    end else begin
      m_ls = 0; m_fs = 0;
    end
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 2 * PT && p != v * HT + h; i++) tick(0, 1);
    if (p != v * HT + h) begin
      errors++;
      $display("FAIL run_to timeout: at index %0d want (%0d,%0d)", p, h, v);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1, 1);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL reset got %h want %h", obs, expv()); end
    end
    checks++;
    if (hcnt !== 12'(HT - 1) || vcnt !== 12'(VT - 1) || de !== 1'b0 || hs !== ~HSP || vs !== ~VSP || ls !== 1'b0 || fs !== 1'b0 || fcnt !== 16'd0) begin
      errors++; $display("FAIL reset_const got %h", obs);
    end
  endtask

  task automatic test_release();
    tick(0, 1);
    checks++;
    if (hcnt !== 12'd0 || vcnt !== 12'd0 || de !== 1'b1 || ls !== 1'b1 || fs !== 1'b1 || fcnt !== 16'd1) begin
      errors++; $display("FAIL release_first got %h", obs);
    end
    tick(0, 1);
    checks++;
    if (hcnt !== 12'd1 || ls !== 1'b0 || fs !== 1'b0 || obs !== expv()) begin
      errors++; $display("FAIL release_second got %h want %h", obs, expv());
    end
  endtask

  task automatic test_line_timing();
    int de_n = 0, hs_n = 0, hs_rise = -1;
    run_to(HT - 1, 2);
    for (int i = 0; i < HT; i++) begin
      tick(0, 1);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL line got %h want %h", obs, expv()); end
      if (i == 0) begin
        checks++;
        if (hcnt !== 12'd0 || vcnt !== 12'd3 || ls !== 1'b1) begin errors++; $display("FAIL line_wrap got %h", obs); end
      end
      if (de === 1'b1) de_n++;
      if (hs === HSP) begin hs_n++; if (hs_rise < 0) hs_rise = int'(hcnt); end
    end
    checks++;
    if (de_n != HA) begin errors++; $display("FAIL line_de_count got %0d want %0d", de_n, HA); end
    checks++;
    if (hs_n != HSW || hs_rise != HA + HF) begin
      errors++; $display("FAIL line_hs got width %0d rise %0d want %0d %0d", hs_n, hs_rise, HSW, HA + HF);
    end
  endtask

  task automatic test_frame_timing();
    int vs_n = 0, fs_n = 0, de_blank = 0;
    bit vwrap = 0;
    for (int i = 0; i < 2 * PT; i++) begin
      tick(0, 1);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL frame got %h want %h", obs, expv()); end
      if (vs === VSP) vs_n++;
      if (fs === 1'b1) fs_n++;
      if (de === 1'b1 && int'(vcnt) >= VA) de_blank++;
      if (hcnt === 12'd0 && vcnt === 12'd0) vwrap = 1;
    end
    checks++;
    if (vs_n != 2 * VSW * HT) begin errors++; $display("FAIL frame_vs_count got %0d want %0d", vs_n, 2 * VSW * HT); end
    checks++;
    if (fs_n != 2 || !vwrap) begin errors++; $display("FAIL frame_start_count got %0d want 2", fs_n); end
    checks++;
    if (de_blank != 0) begin errors++; $display("FAIL frame_de_blank got %0d want 0", de_blank); end
    checks++;
    if (fcnt !== 16'(m_fc)) begin errors++; $display("FAIL frame_cnt got %0d want %0d", fcnt, m_fc); end
  endtask

  task automatic test_enable_hold();
    run_to(HT - 1, 10);
    for (int i = 0; i < 100; i++) begin
      tick(0, 0);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL hold got %h want %h", obs, expv()); end
    end
    tick(0, 1);
    checks++;
    if (hcnt !== 12'd0 || vcnt !== 12'd11 || ls !== 1'b1 || fs !== 1'b0 || obs !== expv()) begin
      errors++; $display("FAIL hold_resume got %h want %h", obs, expv());
    end
  endtask

  task automatic test_reset_mid();
    run_to(20, 5);
    tick(1, 1);
    checks++;
    if (hcnt !== 12'(HT - 1) || vcnt !== 12'(VT - 1) || fcnt !== 16'd0 || ls !== 1'b0 || obs !== expv()) begin
      errors++; $display("FAIL reset_mid got %h want %h", obs, expv());
    end
    tick(0, 1);
    checks++;
    if (hcnt !== 12'd0 || vcnt !== 12'd0 || fs !== 1'b1 || fcnt !== 16'd1 || obs !== expv()) begin
      errors++; $display("FAIL reset_mid_restart got %h want %h", obs, expv());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL random cycle %0d got %h want %h", i, obs, expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_line_timing();
    test_frame_timing();
    test_enable_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Video timing generator that produces the raster counters `i_hcnt`/`i_vcnt` consumed by the pixel/sprite renderers, plus sync, data-enable and frame/line strobes for the HDMI/DVI output stage. It runs on the 74.25 MHz pixel clock with 1280x720p60 defaults. Active video starts at count 0, so renderers use the counters directly as pixel coordinates.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level

Ports:
- i_clk_74M  input  1  74.25 MHz pixel clock
- i_rst  input  1  synchronous reset, active-high
- i_en  input  1  count enable; low freezes timing
- o_hcnt  output  12  horizontal counter, 0..H_TOTAL-1
- o_vcnt  output  12  vertical counter, 0..V_TOTAL-1
- o_hs  output  1  horizontal sync, polarity HS_POL
- o_vs  output  1  vertical sync, polarity VS_POL
- o_de  output  1  data enable, high in the active area
- o_line_start  output  1  one-cycle pulse at o_hcnt==0
- o_frame_start  output  1  one-cycle pulse at o_hcnt==0 && o_vcnt==0
- o_frame_cnt  output  16  frames started since reset, wraps

Behaviour:
- Clock and reset: single clock i_clk_74M. Reset is synchronous and active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650 by default). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750 by default). Both totals must be ≤ 4096; elaborate-time check.
- Registered outputs: every output is a register. o_hs, o_vs, o_de and the pulses always describe the pixel at the current o_hcnt/o_vcnt in the same cycle. Implement this by decoding from next-state counts; there is no extra pipeline skew.
- Reset values (held while i_rst=1):
  - o_hcnt = H_TOTAL-1, o_vcnt = V_TOTAL-1 (last back-porch pixel)
  - o_de = 0, o_hs = ~HS_POL, o_vs = ~VS_POL
  - o_line_start = 0, o_frame_start = 0, o_frame_cnt = 0
- First cycle after reset release (with i_en=1): counters wrap to (0,0), o_de=1, o_line_start=1, o_frame_start=1, o_frame_cnt=1.
- Counting, when i_en=1 each clock:
  - If hcnt==H_TOTAL-1: hcnt←0. Then vcnt←0 if vcnt==V_TOTAL-1, else vcnt+1.
  - Otherwise hcnt←hcnt+1 and vcnt holds.
- Decodes:
  - de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE)
  - hs active when H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC (1390..1429 by default)
  - vs active when V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC (725..729 by default). vs changes only at hcnt==0 (progressive, line-aligned).
- o_frame_cnt increments in the same cycle o_frame_start is asserted and wraps 65535→0.
- When i_en=0: counters, o_hs, o_vs, o_de and o_frame_cnt hold their values. o_line_start and o_frame_start are forced to 0. On re-enable, counting resumes from the held position, and a pulse is emitted only if the next position is hcnt==0.
- Reset mid-frame: counts return to the reset values on the next edge. Any pulse in flight is dropped, with no partial-line artefact beyond that cycle.
- Simultaneous i_rst and i_en: reset wins.

Test Plan:
- Reset values: hold i_rst=1 for 5 clocks → o_hcnt=1649, o_vcnt=749, o_de=0, o_hs=0, o_vs=0, all pulses 0, o_frame_cnt=0.
- Release with i_en=1 → next cycle o_hcnt=0, o_vcnt=0, o_de=1, o_line_start=1, o_frame_start=1, o_frame_cnt=1. The cycle after that has hcnt=1 and both pulses 0.
- Line timing: over one line, o_de is high for exactly 1280 cycles (hcnt 0..1279). o_hs rises at hcnt=1390 and falls at hcnt=1430 (40 cycles). hcnt wraps 1649→0 with vcnt+1 and o_line_start=1.
- Frame timing: run 2 full frames (2×1,237,500 cycles).
  - o_vs is high for exactly 5×1650 cycles, from (0,725) to (1649,729).
  - o_de is low on lines 720..749.
  - vcnt wraps 749→0.
  - o_frame_start fires exactly once per 1,237,500 cycles; o_frame_cnt reaches 3.
- Enable hold: drop i_en for 100 cycles at (1649,10) → all outputs frozen and pulses 0. On re-enable, the next cycle is (0,11) with o_line_start=1.
- Reset mid-frame: assert i_rst for 1 cycle at (500,300) → next cycle shows the reset values. The following cycle is (0,0) with o_frame_start=1 and o_frame_cnt=1.
